mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences and shares the single-ported unified instruction/data memory of the multicycle CPU between two requesters: the CPU memory port (fetch and load/store) and the program loader/debug port. Each access is a one-shot req/ready transaction held in a registered address/data buffer for a fixed number of wait cycles. The arbiter sits between both requesters and the memory macro, and its ready pulse is what the CPU control FSM waits on before leaving a memory state.

## Interface
- AW, 32, address width
- DW, 32, data width
- WAIT_CYCLES, 1, extra memory cycles per access (0..15); ACCESS lasts WAIT_CYCLES+1 cycles
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req / cpu_we  in  1 / 1  CPU access request / write enable
- cpu_addr / cpu_wdata  in  AW / DW  CPU address / write data
- cpu_ready  out  1  one-cycle pulse: CPU access complete
- cpu_rdata  out  DW  read data, valid from cpu_ready until next read completes
- ld_req, ld_we, ld_addr, ld_wdata  in  1,1,AW,DW  loader request fields, same meaning as CPU
- ld_ready  out  1  one-cycle pulse: loader access complete
- ld_rdata  out  DW  loader read data, same rule as cpu_rdata
- mem_en / mem_we  out  1 / 1  memory enable / write strobe
- mem_addr / mem_wdata  out  AW / DW  memory address / write data
- mem_rdata  in  DW  memory read data, valid on last ACCESS cycle

## Operation
- States: IDLE, ACCESS, DONE. Reset: IDLE, cnt=0, gnt=LD (last granted = loader, so CPU wins first tie), addr_q/wdata_q/we_q/rdata_q = 0, every output 0.
- IDLE: no req -> stay. One req -> grant it. Both -> grant the one not equal to last gnt (round-robin). On grant: latch addr/wdata/we of winner, gnt<=winner, cnt<=WAIT_CYCLES, -> ACCESS.
- ACCESS: mem_en=1, mem_addr=addr_q, mem_wdata=wdata_q, mem_we=we_q for every ACCESS cycle. cnt!=0 -> cnt-1, stay. cnt==0 -> if !we_q, rdata_q<=mem_rdata; -> DONE.
- DONE: ready of gnt requester =1 for this cycle only; other ready 0; mem_en=0; -> IDLE.
- cpu_rdata and ld_rdata both drive rdata_q; writes leave rdata_q unchanged.
- Outside ACCESS, mem_en=mem_we=0; mem_addr/mem_wdata show addr_q/wdata_q (don't-care).
- Requester contract: hold req and fields stable until its ready; drop req in the cycle after ready. Req still high in the IDLE after DONE is a new request.
- Req dropped mid-transaction: ignored; access completes and ready still pulses.
- Inputs of the non-granted requester are never sampled outside IDLE.

## Timing
- Req sampled in IDLE at edge 0 -> ACCESS cycles 1..WAIT_CYCLES+1 -> ready in cycle WAIT_CYCLES+2.
- Full transaction WAIT_CYCLES+3 cycles; peak throughput one access per WAIT_CYCLES+3 cycles.
- All outputs decoded from registered state/gnt/latched fields, with no combinational path from req inputs to any output.
- Reset mid-ACCESS: mem_en/mem_we fall asynchronously, no ready pulse, gnt=LD, so CPU wins the next tie. An interrupted write may be partial, and software reloads.
- WAIT_CYCLES=0: single ACCESS cycle, ready in cycle 2.

## Structure
- Package mem_arb_pkg: state enum typedef (IDLE, ACCESS, DONE); grant constants GNT_CPU=1'b0, GNT_LD=1'b1; cnt width constant 4.
- One natural sub-module: arb_wait_counter (load, decrement, zero flag), reused for later peripheral wait states. Everything else lives in the top.

## Test plan
- Reset held, then released with no reqs -> all outputs 0, mem_en never asserted for 10 cycles.
- WAIT_CYCLES=1, CPU read addr 0x10, mem_rdata=0xDEADBEEF -> mem_en high cycles 1–2 with mem_addr 0x10, cpu_ready pulse cycle 3, cpu_rdata=0xDEADBEEF, ld_ready stays 0.
- Both req in same cycle right after reset -> CPU granted first (cpu_ready cycle 3). Loader granted in following IDLE (cycle 4), ld_ready cycle 7.
- Loader write addr 0x40 data 0x00001234 -> mem_we=mem_en=1 cycles 1–2, mem_wdata=0x1234, ld_ready cycle 3, ld_rdata unchanged from prior read.
- Both requesters hold req continuously for 4 transactions -> grants alternate CPU, LD, CPU, LD, with each ready exactly one cycle.
- Reset asserted in cycle 1 of a CPU ACCESS -> mem_en low immediately, no cpu_ready. After release with both req high, CPU is granted first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
// Contents: FSM state enum, grant encodings, wait counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_LD  = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - loadable down-counter for memory wait states
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   load, load_val    load the counter with load_val
//   dec               decrement by one (saturates at zero)
//   zero              counter currently holds zero
module arb_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory between CPU and loader
// Ports:
//   clk, reset                                  clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata, cpu_ready/rdata      CPU memory port (one-shot req/ready)
//   ld_req/we/addr/wdata, ld_ready/rdata        program loader / debug port
//   mem_en/we/addr/wdata, mem_rdata             single-ported memory macro
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ready,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ready,
    output logic [DW-1:0] ld_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t    state, next_state;
    logic          gnt;
    logic          winner;
    logic          grant;
    logic          capture;
    logic          cnt_load;
    logic          cnt_dec;
    logic          cnt_zero;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;
    logic [DW-1:0] rdata_q;

    arb_wait_counter #(
        .W (CNT_W)
    ) u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CNT_W'(WAIT_CYCLES)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        winner     = gnt;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || ld_req) begin
                    grant    = 1'b1;
                    cnt_load = 1'b1;
                    // On a tie the requester served last time yields.
                    if (cpu_req && ld_req) begin
                        winner = ~gnt;
                    end else begin
                        winner = cpu_req ? GNT_CPU : GNT_LD;
                    end
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_zero) begin
                    capture    = ~we_q;
                    next_state = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Winner's fields are latched once at grant; requester inputs are not
    // looked at again until the arbiter is back in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt     <= GNT_LD;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (grant) begin
                gnt     <= winner;
                addr_q  <= (winner == GNT_CPU) ? cpu_addr  : ld_addr;
                wdata_q <= (winner == GNT_CPU) ? cpu_wdata : ld_wdata;
                we_q    <= (winner == GNT_CPU) ? cpu_we    : ld_we;
            end
            if (capture) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_en    = (state == ACCESS);
    assign mem_we    = (state == ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign cpu_ready = (state == DONE) && (gnt == GNT_CPU);
    assign ld_ready  = (state == DONE) && (gnt == GNT_LD);
    assign cpu_rdata = rdata_q;
    assign ld_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int W  = 1;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          ld_req = 1'b0, ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_wdata = '0;
    logic          cpu_ready, ld_ready, mem_en, mem_we;
    logic [DW-1:0] cpu_rdata, ld_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ready(ld_ready), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_pat(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {24'hA5C300, a};
    endfunction

    // Memory macro stand-in: preset contents plus anything written.
    bit          wr_valid [256];
    logic [31:0] wr_data  [256];
    assign mem_rdata = wr_valid[mem_addr[7:0]] ? wr_data[mem_addr[7:0]] : init_pat(mem_addr[7:0]);
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wr_valid[mem_addr[7:0]] <= 1'b1;
            wr_data[mem_addr[7:0]]  <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: k counts clock edges since the grant
    // (0 = free). Access cycles are k=1..W+1, ready at k=W+2.
    int          k;
    logic        m_last, m_gnt, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    bit          mv [256];
    logic [31:0] md [256];

    function automatic logic pick(input logic c, input logic l, input logic last);
        if (c && l) return ~last;
        return c ? 1'b0 : 1'b1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k       <= 0;
            m_last  <= 1'b1;
            m_gnt   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_rdata <= '0;
        end else if (k == 0) begin
            if (cpu_req || ld_req) begin
                m_gnt   <= pick(cpu_req, ld_req, m_last);
                m_last  <= pick(cpu_req, ld_req, m_last);
                m_we    <= pick(cpu_req, ld_req, m_last) ? ld_we    : cpu_we;
                m_addr  <= pick(cpu_req, ld_req, m_last) ? ld_addr  : cpu_addr;
                m_wdata <= pick(cpu_req, ld_req, m_last) ? ld_wdata : cpu_wdata;
                k       <= 1;
            end
        end else if (k == W + 2) begin
            k <= 0;
        end else begin
            k <= k + 1;
            if (k == W + 1) begin
                if (m_we) begin
                    mv[m_addr[7:0]] <= 1'b1;
                    md[m_addr[7:0]] <= m_wdata;
                end else begin
                    m_rdata <= mv[m_addr[7:0]] ? md[m_addr[7:0]] : init_pat(m_addr[7:0]);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("mem_en", 32'(mem_en), 32'((k >= 1) && (k <= W + 1)));
        chk("mem_we", 32'(mem_we), 32'((k >= 1) && (k <= W + 1) && m_we));
        if ((k >= 1) && (k <= W + 1)) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("cpu_ready", 32'(cpu_ready), 32'((k == W + 2) && (m_gnt == 1'b0)));
        chk("ld_ready", 32'(ld_ready), 32'((k == W + 2) && (m_gnt == 1'b1)));
        chk("cpu_rdata", cpu_rdata, m_rdata);
        chk("ld_rdata", ld_rdata, m_rdata);
    end

    // Directed observation window; cycle c is the period after the c-th edge
    // counted from the edge that samples the request.
    int          cpu_rdy_q[$];
    int          ld_rdy_q[$];
    bit [63:0]   en_m, we_m;
    logic [31:0] first_addr, first_wdata;
    bit          keep = 1'b0;

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic watch(input int n);
        bit cr, lr;
        cpu_rdy_q.delete();
        ld_rdy_q.delete();
        en_m = '0;
        we_m = '0;
        first_addr = '0;
        first_wdata = '0;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            cr = cpu_ready;
            lr = ld_ready;
            if (cr) cpu_rdy_q.push_back(c);
            if (lr) ld_rdy_q.push_back(c);
            if (mem_en) begin
                if (en_m == '0) begin
                    first_addr = mem_addr;
                    first_wdata = mem_wdata;
                end
                en_m[c] = 1'b1;
            end
            if (mem_we) we_m[c] = 1'b1;
            @(negedge clk);
            if (!keep) begin
                if (cr) cpu_req = 1'b0;
                if (lr) ld_req = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cpu_req = 1'b0;
        ld_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        watch(10);
        chk("idle_en_mask", 32'(en_m), 32'd0);
        chk("idle_cpu_rdy_n", 32'(cpu_rdy_q.size()), 32'd0);
        chk("idle_ld_rdy_n", 32'(ld_rdy_q.size()), 32'd0);
        chk("idle_cpu_rdata", cpu_rdata, 32'd0);

        // CPU read of 0x10
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        watch(6);
        chk("rd_en_mask", 32'(en_m), 32'h6);
        chk("rd_addr", first_addr, 32'h10);
        chk("rd_cpu_rdy_n", 32'(cpu_rdy_q.size()), 32'd1);
        chk("rd_cpu_rdy_cyc", 32'(q_at(cpu_rdy_q, 0)), 32'd3);
        chk("rd_ld_rdy_n", 32'(ld_rdy_q.size()), 32'd0);
        chk("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

        // Simultaneous requests right after reset: CPU first
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
        ld_req = 1'b1;  ld_we = 1'b0;  ld_addr = 32'h20;
        watch(10);
        chk("tie_cpu_rdy_cyc", 32'(q_at(cpu_rdy_q, 0)), 32'd3);
        chk("tie_ld_rdy_cyc", 32'(q_at(ld_rdy_q, 0)), 32'd7);
        chk("tie_ld_rdata", ld_rdata, 32'hA5C30020);

        // Loader write; read data must not change
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h40; ld_wdata = 32'h00001234;
        watch(6);
        chk("wr_en_mask", 32'(en_m), 32'h6);
        chk("wr_we_mask", 32'(we_m), 32'h6);
        chk("wr_addr", first_addr, 32'h40);
        chk("wr_wdata", first_wdata, 32'h00001234);
        chk("wr_ld_rdy_cyc", 32'(q_at(ld_rdy_q, 0)), 32'd3);
        chk("wr_ld_rdata_kept", ld_rdata, 32'hA5C30020);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        watch(6);
        chk("rdback_cpu_rdata", cpu_rdata, 32'h00001234);

        // Both requesters hold req: strict alternation
        do_reset();
        keep = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        ld_req = 1'b1;  ld_we = 1'b0;  ld_addr = 32'h20;
        watch(15);
        keep = 1'b0;
        cpu_req = 1'b0;
        ld_req = 1'b0;
        chk("rr_cpu_rdy0", 32'(q_at(cpu_rdy_q, 0)), 32'd3);
        chk("rr_ld_rdy0", 32'(q_at(ld_rdy_q, 0)), 32'd7);
        chk("rr_cpu_rdy1", 32'(q_at(cpu_rdy_q, 1)), 32'd11);
        chk("rr_ld_rdy1", 32'(q_at(ld_rdy_q, 1)), 32'd15);
        chk("rr_cpu_rdy_n", 32'(cpu_rdy_q.size()), 32'd2);
        chk("rr_ld_rdy_n", 32'(ld_rdy_q.size()), 32'd2);
        watch(3);

        // Reset in the first ACCESS cycle of a CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        @(posedge clk);
        #2;
        chk("rst_pre_en", 32'(mem_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_en", 32'(mem_en), 32'd0);
        chk("rst_async_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h20;
        keep = 1'b1;
        watch(2);
        keep = 1'b0;
        chk("rst_no_cpu_rdy", 32'(cpu_rdy_q.size()), 32'd0);
        reset = 1'b0;
        watch(10);
        chk("rst_cpu_first", 32'(q_at(cpu_rdy_q, 0)), 32'd3);
        chk("rst_ld_second", 32'(q_at(ld_rdy_q, 0)), 32'd7);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
